// File: rtl/shift_unit_seq.sv
// Iterative multicycle shifter: one bit position per clock, start/busy/done handshake.
// Supports SLL, SRL, SRA, ROL, ROR and PASS; result register drives data_out directly.
module shift_unit_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpRol = 3'b011;
  localparam logic [2:0] OpRor = 3'b100;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   stepped;
  logic               op_is_pass;

  // Codes 101..111 pass the operand through untouched.
  assign op_is_pass = op[2] & (op[1] | op[0]);

  always_comb begin
    stepped = result_q;
    case (op_q)
      OpSll:   stepped = {result_q[WIDTH-2:0], 1'b0};
      OpSrl:   stepped = {1'b0, result_q[WIDTH-1:1]};
      OpSra:   stepped = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      OpRol:   stepped = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
      OpRor:   stepped = {result_q[0], result_q[WIDTH-1:1]};
      default: stepped = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          result_d = data_in;
          op_d     = op;
          count_d  = shamt;
          if ((shamt != '0) && !op_is_pass) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        result_d = stepped;
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= 3'b000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign busy     = (state_q == StShift);
  assign done     = (state_q == StDone);
  assign data_out = result_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed-vector bench for shift_unit_seq: table of operations with hand-computed
// results and latencies, plus reset, ignored-start and mid-operation-reset sequences.
module tb_shift_unit_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int n_vec;
  int n_err;

  shift_unit_seq #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] din;
    logic [4:0]  sh;
    logic        intf;  // hammer start with junk while busy
    logic [31:0] exp;
    int          lat;   // cycles from start edge to done
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int          cyc;
    int          bsy;
    logic        both;
    logic [31:0] held;
    data_in = v.din;
    shamt   = v.sh;
    op      = v.op;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (v.intf) begin
      data_in = 32'hFFFF_FFFF;
      shamt   = 5'd1;
      op      = 3'b001;
      start   = 1'b1;
    end
    cyc  = 1;
    bsy  = 0;
    both = 1'b0;
    while (!done && cyc < 40) begin
      if (busy) bsy++;
      if (v.intf && cyc == 3) start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (busy && done) both = 1'b1;
    end
    start = 1'b0;
    check($sformatf("v%0d done_seen", idx), {31'd0, done}, 32'd1);
    check($sformatf("v%0d latency", idx), cyc, v.lat);
    check($sformatf("v%0d busy_cycles", idx), bsy, v.lat - 1);
    check($sformatf("v%0d busy_and_done", idx), {31'd0, both}, 32'd0);
    check($sformatf("v%0d data_out", idx), data_out, v.exp);
    held = data_out;
    @(posedge clk);
    #1;
    check($sformatf("v%0d done_one_cycle", idx), {31'd0, done}, 32'd0);
    check($sformatf("v%0d result_held", idx), data_out, held);
  endtask

  vec_t vecs[16];

  initial begin
    logic saw_done;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'b000;
    data_in = 32'h0;
    shamt   = 5'd0;

    //       op      din            sh  intf  exp            lat
    vecs[0]  = '{3'b000, 32'h0000_0001, 5'd4,  1'b0, 32'h0000_0010, 5};
    vecs[1]  = '{3'b010, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 32};
    vecs[2]  = '{3'b001, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32};
    vecs[3]  = '{3'b011, 32'h8000_0001, 5'd1,  1'b0, 32'h0000_0003, 2};
    vecs[4]  = '{3'b100, 32'h8000_0001, 5'd1,  1'b0, 32'hC000_0000, 2};
    vecs[5]  = '{3'b000, 32'h8000_0001, 5'd0,  1'b0, 32'h8000_0001, 1};
    vecs[6]  = '{3'b000, 32'h0000_0001, 5'd4,  1'b1, 32'h0000_0010, 5};
    vecs[7]  = '{3'b001, 32'h0000_000F, 5'd2,  1'b0, 32'h0000_0003, 3};
    vecs[8]  = '{3'b000, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000, 32};
    vecs[9]  = '{3'b011, 32'h8000_0001, 5'd31, 1'b0, 32'hC000_0000, 32};
    vecs[10] = '{3'b100, 32'h8000_0001, 5'd31, 1'b0, 32'h0000_0003, 32};
    vecs[11] = '{3'b101, 32'h1234_5678, 5'd7,  1'b0, 32'h1234_5678, 1};
    vecs[12] = '{3'b010, 32'h7000_0000, 5'd4,  1'b0, 32'h0700_0000, 5};
    vecs[13] = '{3'b001, 32'hDEAD_BEEF, 5'd8,  1'b0, 32'h00DE_ADBE, 9};
    vecs[14] = '{3'b100, 32'h1234_5678, 5'd4,  1'b0, 32'h8123_4567, 5};
    vecs[15] = '{3'b011, 32'h1234_5678, 5'd8,  1'b0, 32'h3456_7812, 9};

    // Reset held for two edges, then idle with start low.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset data_out", data_out, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle%0d outputs", i), {busy, done, 30'd0} | 32'(data_out != 0), 32'd0);
    end

    // Back-to-back: each run_op ends in the IDLE cycle right after DONE.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], i);
    end

    // Mid-operation reset: SLL by 10, reset asserted in cycle 4 after start.
    data_in = 32'h0000_0001;
    shamt   = 5'd10;
    op      = 3'b000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("midreset busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset data_out", data_out, 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("midreset no_done", {31'd0, saw_done}, 32'd0);
    check("midreset data_out_after", data_out, 32'h0);

    // Reset wins over start in the same cycle.
    data_in = 32'hA5A5_A5A5;
    shamt   = 5'd0;
    start   = 1'b1;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_vs_start done", {31'd0, done}, 32'd0);
    check("reset_vs_start data_out", data_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
